// File: rtl/adder_response_checker.sv
// Adder response checker: compares {cout,sum} against a+b for a fixed-length run of
// vectors. It counts passes and fails, captures the first failing vector and raises
// done once the last result has landed.
module adder_response_checker #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned NUM_VEC = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 err_flag,
  output logic [3*WIDTH:0]     ff_vec
);

  localparam int unsigned VEC_W = 3 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    acc_cnt;
  logic                accept;
  logic                last_vec;
  logic                start_ok;

  logic                p_vld;
  logic [WIDTH-1:0]    p_a;
  logic [WIDTH-1:0]    p_b;
  logic [WIDTH-1:0]    p_sum;
  logic                p_cout;
  logic [WIDTH:0]      exp_sum;
  logic                mismatch;

  // Handshake and status decode straight from the state register
  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign accept   = in_valid && in_ready;
  assign last_vec = (acc_cnt == CNT_W'(NUM_VEC - 1));
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  // Run sequencing: state, accept counter and done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc_cnt <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (accept && last_vec) state <= DRAIN;
        DRAIN:   state <= DONE;
        DONE:    if (start) state <= RUN;
        default: state <= IDLE;
      endcase

      if (start_ok) begin
        acc_cnt <= '0;
      end else if (accept) begin
        acc_cnt <= acc_cnt + CNT_W'(1);
      end

      // done follows the final counter update by one cycle
      if (start_ok) begin
        done <= 1'b0;
      end else if (state == DONE) begin
        done <= 1'b1;
      end
    end
  end

  // Capture stage: register an accepted vector alongside its valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld  <= 1'b0;
      p_a    <= '0;
      p_b    <= '0;
      p_sum  <= '0;
      p_cout <= 1'b0;
    end else begin
      p_vld <= accept;
      if (accept) begin
        p_a    <= a;
        p_b    <= b;
        p_sum  <= sum;
        p_cout <= cout;
      end
    end
  end

  // Full-width reference so the carry is part of the compare
  assign exp_sum  = {1'b0, p_a} + {1'b0, p_b};
  assign mismatch = ({p_cout, p_sum} != exp_sum);

  // Result bookkeeping: saturating counters, sticky error, first-fail capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_flag <= 1'b0;
      ff_vec   <= '0;
    end else if (start_ok) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_flag <= 1'b0;
      ff_vec   <= '0;
    end else if (p_vld) begin
      if (mismatch) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        if (!err_flag) ff_vec <= VEC_W'({p_a, p_b, p_cout, p_sum});
        err_flag <= 1'b1;
      end else begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      end
    end
  end

endmodule
